decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ILLEGAL_AS_NOP, default 1: when 1, an illegal instruction has all side-effect controls forced to 0.
REQ-002 Port clk_i  in  1  clock; all state changes on the rising edge.
REQ-003 Port rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 Port in_valid_i  in  1  fetch presents an instruction.
REQ-005 Port in_ready_o  out  1  stage accepts the instruction this cycle.
REQ-006 Port in_instr_i  in  32  raw instruction word.
REQ-007 Port in_pc_i  in  32  PC of in_instr_i.
REQ-008 Port flush_i  in  1  kill the held instruction; ignore input this cycle.
REQ-009 Port out_valid_o  out  1  decoded instruction valid.
REQ-010 Port out_ready_i  in  1  execute consumes the output this cycle.
REQ-011 Ports out_pc_o / out_instr_o  out  32 each  registered PC and instruction.
REQ-012 Ports rs1_o, rs2_o, rd_o  out  5 each  register indices.
REQ-013 Port imm_o  out  32  sign-extended immediate.
REQ-014 Port alu_op_o  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
REQ-015 Ports src_a_pc_o, src_b_imm_o  out  1 each  operand A = PC (else rs1); operand B = imm (else rs2).
REQ-016 Ports reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o, illegal_o  out  1 each  control flags.
REQ-017 Port br_cond_o  out  3  funct3 of the branch.

Function
REQ-018 The stage shall be a single-entry pipeline register; all outputs are registered, latency 1 cycle from accept.
REQ-019 in_ready_o shall equal (!out_valid_o || out_ready_i), combinationally.
REQ-020 Accept occurs when in_valid_i && in_ready_o && !flush_i; the decode of in_instr_i and in_pc_i is loaded and out_valid_o=1.
REQ-021 When out_valid_o && !out_ready_i, all outputs shall hold stable.
REQ-022 When out_ready_i && out_valid_o and there is no accept, out_valid_o shall go to 0 and the data fields shall hold their values.
REQ-023 flush_i shall take priority over accept: next cycle out_valid_o=0 and all fields are loaded with the NOP decode (REQ-031).
REQ-024 Decode shall cover the opcodes LW, ALU_I, AUIPC, SW, ALU, LUI, BRANCH, JAL.
REQ-025 ALU: alu_op from funct3. funct7=0100000 shall be legal only with ADD_SUB (->SUB) or SRL_SRA (->SRA). Other funct7 values besides 0 are illegal. reg_we=1.
REQ-026 ALU_I: I-immediate, src_b_imm=1. SLL requires imm[11:5]=0. SRL_SRA requires imm[11:5] of 0 (->SRL) or 0100000 (->SRA). Other values are illegal.
REQ-027 LW (funct3 010 only): ADD, src_b_imm=1, mem_re=1, reg_we=1. SW (funct3 010 only): S-immediate, ADD, src_b_imm=1, mem_we=1.
REQ-028 LUI: U-immediate, PASS_B, reg_we=1. AUIPC: U-immediate, ADD, src_a_pc=1, src_b_imm=1, reg_we=1.
REQ-029 BRANCH: B-immediate, branch=1, br_cond=funct3, operands rs1/rs2. funct3 010/011 are illegal.
REQ-030 JAL: J-immediate, ADD, src_a_pc=1, src_b_imm=1, jump=1, reg_we=1.
REQ-031 rd=0 shall force reg_we_o=0. The NOP decode is instr 0x00000033: ADD, all indices 0, imm 0, all flags 0.
REQ-032 Unknown opcode or an illegal field shall set illegal_o=1. With ILLEGAL_AS_NOP=1, reg_we/mem_re/mem_we/branch/jump shall be 0 and out_valid_o shall still be 1.
REQ-033 Immediates shall be sign-extended from bit 31; the B and J immediates have bit 0 = 0; the U immediate has bits 11:0 = 0.

Reset
REQ-034 rstn_i low shall immediately clear out_valid_o and load the NOP decode with out_pc_o=0. This applies mid-operation; any held instruction is lost.
REQ-035 Release of rstn_i shall take effect synchronously to clk_i; the first accept is possible in the first cycle after release.

Verification
REQ-036 addi x1,x0,5 (0x00500093), pc 0x100 -> next cycle: out_valid=1, rd=1, rs1=0, imm=5, alu ADD, src_b_imm=1, reg_we=1, out_pc=0x100.
REQ-037 sub x3,x1,x2 (0x402081B3) -> alu SUB, rs1=1, rs2=2, rd=3, src_b_imm=0; funct7 0x40 with XOR (0x4020C1B3) -> illegal_o=1, reg_we=0.
REQ-038 beq x1,x2,-4 (0xFE208EE3) -> branch=1, br_cond=0, imm=0xFFFFFFFC, reg_we=0.
REQ-039 out_ready_i=0 for 3 cycles with a held instruction -> in_ready_o=0 and outputs unchanged. Then out_ready_i=1 with in_valid_i=1 -> the new decode appears the next cycle, with no bubble and no duplicate.
REQ-040 flush_i=1 with in_valid_i=1 -> next cycle out_valid=0, out_instr=0x00000033. 0xFFFFFFFF input -> illegal_o=1, all side-effect flags 0.
REQ-041 rstn_i asserted between edges while out_valid=1 -> out_valid=0 before the next edge; the first post-release accept decodes normally.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-entry decode pipeline register for an RV32I subset
module decode_stage #(
   parameter bit ILLEGAL_AS_NOP = 1'b1
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_instr_i,
   input  logic [31:0] in_pc_i,
   input  logic        flush_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_pc_o,
   output logic [31:0] out_instr_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o,
   output logic [31:0] imm_o,
   output logic [3:0]  alu_op_o,
   output logic        src_a_pc_o,
   output logic        src_b_imm_o,
   output logic        reg_we_o,
   output logic        mem_re_o,
   output logic        mem_we_o,
   output logic        branch_o,
   output logic        jump_o,
   output logic        illegal_o,
   output logic [2:0]  br_cond_o
);

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_ALU_I  = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic        src_a_pc;
      logic        src_b_imm;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
      logic        branch;
      logic        jump;
      logic        illegal;
      logic [2:0]  br_cond;
   } dec_t;

   // NOP decode: addi-free "add x0,x0,x0" with PC 0 and every flag cleared
   localparam dec_t NOP_DEC = dec_t'({32'h0, 32'h0000_0033, 62'h0});

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [3:0]  alu_f3;
   logic        legal;
   logic        accept;
   logic        valid_q;
   dec_t        dec;
   dec_t        dec_q;

   assign opcode = in_instr_i[6:0];
   assign funct3 = in_instr_i[14:12];
   assign funct7 = in_instr_i[31:25];

   assign imm_i = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
   assign imm_s = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
   assign imm_b = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                   in_instr_i[30:25], in_instr_i[11:8], 1'b0};
   assign imm_u = {in_instr_i[31:12], 12'h000};
   assign imm_j = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                   in_instr_i[20], in_instr_i[30:21], 1'b0};

   assign in_ready_o = !valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o && !flush_i;

   // Base ALU operation selected by funct3 (funct7 variants patched in the decoder)
   always_comb begin
      alu_f3 = ALU_ADD;
      case (funct3)
         3'd0: alu_f3 = 4'd0;
         3'd1: alu_f3 = 4'd2;
         3'd2: alu_f3 = 4'd3;
         3'd3: alu_f3 = 4'd4;
         3'd4: alu_f3 = 4'd5;
         3'd5: alu_f3 = 4'd6;
         3'd6: alu_f3 = 4'd8;
         3'd7: alu_f3 = 4'd9;
         default: alu_f3 = ALU_ADD;
      endcase
   end

   // Instruction decoder: fields only meaningful to the format are populated
   always_comb begin
      dec       = NOP_DEC;
      dec.pc    = in_pc_i;
      dec.instr = in_instr_i;
      legal     = 1'b1;
      case (opcode)
         OP_ALU: begin
            dec.rs1    = in_instr_i[19:15];
            dec.rs2    = in_instr_i[24:20];
            dec.rd     = in_instr_i[11:7];
            dec.reg_we = 1'b1;
            dec.alu_op = alu_f3;
            if (funct7 == 7'b0100000) begin
               if (funct3 == 3'd0)      dec.alu_op = ALU_SUB;
               else if (funct3 == 3'd5) dec.alu_op = ALU_SRA;
               else                     legal = 1'b0;
            end else if (funct7 != 7'b0000000) begin
               legal = 1'b0;
            end
         end
         OP_ALU_I: begin
            dec.rs1       = in_instr_i[19:15];
            dec.rd        = in_instr_i[11:7];
            dec.imm       = imm_i;
            dec.src_b_imm = 1'b1;
            dec.reg_we    = 1'b1;
            dec.alu_op    = alu_f3;
            if (funct3 == 3'd1 && funct7 != 7'b0000000) legal = 1'b0;
            if (funct3 == 3'd5) begin
               if (funct7 == 7'b0100000)      dec.alu_op = ALU_SRA;
               else if (funct7 != 7'b0000000) legal = 1'b0;
            end
         end
         OP_LW: begin
            dec.rs1       = in_instr_i[19:15];
            dec.rd        = in_instr_i[11:7];
            dec.imm       = imm_i;
            dec.src_b_imm = 1'b1;
            dec.mem_re    = 1'b1;
            dec.reg_we    = 1'b1;
            legal         = (funct3 == 3'b010);
         end
         OP_SW: begin
            dec.rs1       = in_instr_i[19:15];
            dec.rs2       = in_instr_i[24:20];
            dec.imm       = imm_s;
            dec.src_b_imm = 1'b1;
            dec.mem_we    = 1'b1;
            legal         = (funct3 == 3'b010);
         end
         OP_LUI: begin
            dec.rd     = in_instr_i[11:7];
            dec.imm    = imm_u;
            dec.alu_op = ALU_PASS_B;
            dec.reg_we = 1'b1;
         end
         OP_AUIPC: begin
            dec.rd        = in_instr_i[11:7];
            dec.imm       = imm_u;
            dec.src_a_pc  = 1'b1;
            dec.src_b_imm = 1'b1;
            dec.reg_we    = 1'b1;
         end
         OP_BRANCH: begin
            dec.rs1     = in_instr_i[19:15];
            dec.rs2     = in_instr_i[24:20];
            dec.imm     = imm_b;
            dec.branch  = 1'b1;
            dec.br_cond = funct3;
            legal       = (funct3 != 3'b010) && (funct3 != 3'b011);
         end
         OP_JAL: begin
            dec.rd        = in_instr_i[11:7];
            dec.imm       = imm_j;
            dec.src_a_pc  = 1'b1;
            dec.src_b_imm = 1'b1;
            dec.jump      = 1'b1;
            dec.reg_we    = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (dec.rd == 5'd0) dec.reg_we = 1'b0;
      dec.illegal = !legal;
      if (!legal && ILLEGAL_AS_NOP) begin
         dec.reg_we = 1'b0;
         dec.mem_re = 1'b0;
         dec.mem_we = 1'b0;
         dec.branch = 1'b0;
         dec.jump   = 1'b0;
      end
   end

   // Pipeline register: flush beats accept, consume without refill only drops valid
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         valid_q <= 1'b0;
         dec_q   <= NOP_DEC;
      end else if (flush_i) begin
         valid_q <= 1'b0;
         dec_q   <= NOP_DEC;
      end else if (accept) begin
         valid_q <= 1'b1;
         dec_q   <= dec;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid_o = valid_q;
   assign out_pc_o    = dec_q.pc;
   assign out_instr_o = dec_q.instr;
   assign rs1_o       = dec_q.rs1;
   assign rs2_o       = dec_q.rs2;
   assign rd_o        = dec_q.rd;
   assign imm_o       = dec_q.imm;
   assign alu_op_o    = dec_q.alu_op;
   assign src_a_pc_o  = dec_q.src_a_pc;
   assign src_b_imm_o = dec_q.src_b_imm;
   assign reg_we_o    = dec_q.reg_we;
   assign mem_re_o    = dec_q.mem_re;
   assign mem_we_o    = dec_q.mem_we;
   assign branch_o    = dec_q.branch;
   assign jump_o      = dec_q.jump;
   assign illegal_o   = dec_q.illegal;
   assign br_cond_o   = dec_q.br_cond;

endmodule
